// File: rtl/sd_init_seq_pkg.sv
// Shared types and constants for the SD-card SPI initialization sequencer.
package sd_types;

  typedef enum logic [3:0] {
    sIDLE,
    sDUMMY,
    sGAP,
    sCMD,
    sRSP,
    sEXTRA,
    sCHECK,
    sDONE,
    sERR
  } sdINITstate_t;

  typedef enum logic [3:0] {
    ERR_NONE    = 4'd0,
    ERR_CMD0    = 4'd1,
    ERR_CMD8    = 4'd2,
    ERR_ACMD41  = 4'd3,
    ERR_CMD58   = 4'd4,
    ERR_TIMEOUT = 4'd5
  } sdINITerr_t;

  // Command index used to select a frame from sd_cmd_frame.
  typedef enum logic [2:0] {
    IDX_CMD0   = 3'd0,
    IDX_CMD8   = 3'd1,
    IDX_CMD55  = 3'd2,
    IDX_ACMD41 = 3'd3,
    IDX_CMD58  = 3'd4
  } sdCMDidx_t;

  localparam logic [7:0] CMD0_BYTE   = 8'h40;
  localparam logic [7:0] CMD8_BYTE   = 8'h48;
  localparam logic [7:0] CMD55_BYTE  = 8'h77;
  localparam logic [7:0] ACMD41_BYTE = 8'h69;
  localparam logic [7:0] CMD58_BYTE  = 8'h7A;

  localparam logic [7:0] CMD0_CRC    = 8'h95;
  localparam logic [7:0] CMD8_CRC    = 8'h87;
  localparam logic [7:0] CMD55_CRC   = 8'h65;
  localparam logic [7:0] ACMD41_CRC  = 8'h77;
  localparam logic [7:0] CMD58_CRC   = 8'hFD;

  localparam logic [31:0] ARG_ZERO   = 32'h0000_0000;
  localparam logic [31:0] CMD8_ARG   = 32'h0000_01AA;
  localparam logic [31:0] ACMD41_ARG = 32'h4000_0000;

  localparam logic [7:0] IDLE_BYTE   = 8'hFF;
  localparam logic [7:0] R1_IDLE     = 8'h01;
  localparam logic [7:0] R1_READY    = 8'h00;
  localparam logic [7:0] CMD8_VHS    = 8'h01;
  localparam logic [7:0] CMD8_CHECK  = 8'hAA;

endpackage

// File: rtl/sd_cmd_frame.sv
// Combinational lookup of one byte of a 6-byte SD command frame.
module sd_cmd_frame
  import sd_types::*;
(
  input  logic [2:0] cmd_idx,
  input  logic [2:0] byte_idx,
  output logic [7:0] frame_byte
);

  logic [7:0]  cmd_byte;
  logic [7:0]  crc_byte;
  logic [31:0] arg;

  // Select command byte, argument and CRC, then pick the requested byte.
  always_comb begin
    cmd_byte = CMD0_BYTE;
    crc_byte = CMD0_CRC;
    arg      = ARG_ZERO;
    case (cmd_idx)
      IDX_CMD8: begin
        cmd_byte = CMD8_BYTE;
        crc_byte = CMD8_CRC;
        arg      = CMD8_ARG;
      end
      IDX_CMD55: begin
        cmd_byte = CMD55_BYTE;
        crc_byte = CMD55_CRC;
      end
      IDX_ACMD41: begin
        cmd_byte = ACMD41_BYTE;
        crc_byte = ACMD41_CRC;
        arg      = ACMD41_ARG;
      end
      IDX_CMD58: begin
        cmd_byte = CMD58_BYTE;
        crc_byte = CMD58_CRC;
      end
      default: ;
    endcase

    case (byte_idx)
      3'd0:    frame_byte = cmd_byte;
      3'd1:    frame_byte = arg[31:24];
      3'd2:    frame_byte = arg[23:16];
      3'd3:    frame_byte = arg[15:8];
      3'd4:    frame_byte = arg[7:0];
      3'd5:    frame_byte = crc_byte;
      default: frame_byte = IDLE_BYTE;
    endcase
  end

endmodule

// File: rtl/sd_init_seq.sv
// SD-card SPI-mode power-up sequencer: dummy clocks, CMD0, CMD8,
// CMD55/ACMD41 loop, CMD58. Drives a byte-level SPI engine one transfer
// at a time and owns chip select and the SPI speed select until done.
module sd_init_seq
  import sd_types::*;
#(
  parameter int DUMMY_BYTES    = 10,
  parameter int RSP_WAIT       = 8,
  parameter int ACMD41_RETRIES = 1000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  output logic [7:0] spiTXD,
  output logic       spiGO,
  input  logic       spiDONE,
  input  logic [7:0] spiRXD,
  output logic       sdCS,
  output logic       spiFAST,
  output logic       busy,
  output logic       initDONE,
  output logic       initERR,
  output logic [3:0] errCODE,
  output logic       sdHC
);

  localparam int DW = $clog2(DUMMY_BYTES + 1);
  localparam int PW = $clog2(RSP_WAIT + 1);
  localparam int RW = $clog2(ACMD41_RETRIES + 1);

  localparam logic [DW-1:0] DUMMY_LAST = DW'(DUMMY_BYTES - 1);
  localparam logic [PW-1:0] POLL_LAST  = PW'(RSP_WAIT - 1);
  localparam logic [RW-1:0] RETRY_LAST = RW'(ACMD41_RETRIES - 1);

  sdINITstate_t   state, state_n;
  sdCMDidx_t      cmd, cmd_n;
  logic [2:0]     byte_cnt, byte_n;
  logic [DW-1:0]  dummy_cnt, dummy_n;
  logic [PW-1:0]  poll_cnt, poll_n;
  logic [RW-1:0]  retry_cnt, retry_n;
  logic           pending, pend_n;
  logic [7:0]     r1, r1_n;
  logic [7:0]     ext_b2, b2_n;
  logic [7:0]     ext_b3, b3_n;
  logic           ccs, ccs_n;

  logic [7:0]     txd_n;
  logic           go_n, cs_n, fast_n, busy_n, done_n, ierr_n, hc_n;
  logic [3:0]     code_n;

  logic           xfer_done;
  logic           fail;
  sdINITerr_t     fail_code;
  logic           advance;
  sdCMDidx_t      adv_cmd;
  logic [7:0]     frame_byte;

  sd_cmd_frame u_frame (
    .cmd_idx    (cmd),
    .byte_idx   (byte_cnt),
    .frame_byte (frame_byte)
  );

  // Register state, counters, captured response bytes and all outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= sIDLE;
      cmd       <= IDX_CMD0;
      byte_cnt  <= '0;
      dummy_cnt <= '0;
      poll_cnt  <= '0;
      retry_cnt <= '0;
      pending   <= 1'b0;
      r1        <= '0;
      ext_b2    <= '0;
      ext_b3    <= '0;
      ccs       <= 1'b0;
      spiTXD    <= IDLE_BYTE;
      spiGO     <= 1'b0;
      sdCS      <= 1'b1;
      spiFAST   <= 1'b0;
      busy      <= 1'b0;
      initDONE  <= 1'b0;
      initERR   <= 1'b0;
      errCODE   <= ERR_NONE;
      sdHC      <= 1'b0;
    end else begin
      state     <= state_n;
      cmd       <= cmd_n;
      byte_cnt  <= byte_n;
      dummy_cnt <= dummy_n;
      poll_cnt  <= poll_n;
      retry_cnt <= retry_n;
      pending   <= pend_n;
      r1        <= r1_n;
      ext_b2    <= b2_n;
      ext_b3    <= b3_n;
      ccs       <= ccs_n;
      spiTXD    <= txd_n;
      spiGO     <= go_n;
      sdCS      <= cs_n;
      spiFAST   <= fast_n;
      busy      <= busy_n;
      initDONE  <= done_n;
      initERR   <= ierr_n;
      errCODE   <= code_n;
      sdHC      <= hc_n;
    end
  end

  // Next-state, transfer issue and response evaluation.
  always_comb begin
    state_n   = state;
    cmd_n     = cmd;
    byte_n    = byte_cnt;
    dummy_n   = dummy_cnt;
    poll_n    = poll_cnt;
    retry_n   = retry_cnt;
    pend_n    = pending;
    r1_n      = r1;
    b2_n      = ext_b2;
    b3_n      = ext_b3;
    ccs_n     = ccs;
    txd_n     = spiTXD;
    go_n      = 1'b0;
    cs_n      = sdCS;
    fast_n    = spiFAST;
    busy_n    = busy;
    done_n    = initDONE;
    ierr_n    = initERR;
    code_n    = errCODE;
    hc_n      = sdHC;
    fail      = 1'b0;
    fail_code = ERR_NONE;
    advance   = 1'b0;
    adv_cmd   = cmd;
    // A DONE pulse with nothing outstanding is stray and ignored.
    xfer_done = pending & spiDONE;

    // One transfer at a time: issue the next byte only once the last completed.
    if ((state inside {sDUMMY, sGAP, sCMD, sRSP, sEXTRA}) && !pending) begin
      go_n   = 1'b1;
      pend_n = 1'b1;
      txd_n  = (state == sCMD) ? frame_byte : IDLE_BYTE;
    end
    if (xfer_done) begin
      pend_n = 1'b0;
    end

    case (state)
      sIDLE, sDONE, sERR: begin
        if (start) begin
          state_n   = sDUMMY;
          cmd_n     = IDX_CMD0;
          byte_n    = '0;
          dummy_n   = '0;
          poll_n    = '0;
          retry_n   = '0;
          cs_n      = 1'b1;
          fast_n    = 1'b0;
          busy_n    = 1'b1;
          done_n    = 1'b0;
          ierr_n    = 1'b0;
          code_n    = ERR_NONE;
          hc_n      = 1'b0;
        end
      end
      sDUMMY: begin
        if (xfer_done) begin
          if (dummy_cnt == DUMMY_LAST) begin
            state_n = sGAP;
            cmd_n   = IDX_CMD0;
          end else begin
            dummy_n = dummy_cnt + 1'b1;
          end
        end
      end
      sGAP: begin
        if (xfer_done) begin
          state_n = sCMD;
          byte_n  = '0;
          cs_n    = 1'b0;
        end
      end
      sCMD: begin
        if (xfer_done) begin
          if (byte_cnt == 3'd5) begin
            state_n = sRSP;
            poll_n  = '0;
          end else begin
            byte_n = byte_cnt + 3'd1;
          end
        end
      end
      sRSP: begin
        if (xfer_done) begin
          if (spiRXD != IDLE_BYTE) begin
            r1_n = spiRXD;
            if (cmd == IDX_CMD8 || cmd == IDX_CMD58) begin
              state_n = sEXTRA;
              byte_n  = '0;
            end else begin
              state_n = sCHECK;
            end
          end else if (poll_cnt == POLL_LAST) begin
            fail      = 1'b1;
            fail_code = ERR_TIMEOUT;
          end else begin
            poll_n = poll_cnt + 1'b1;
          end
        end
      end
      sEXTRA: begin
        if (xfer_done) begin
          case (byte_cnt)
            3'd0:    ccs_n = spiRXD[6];
            3'd2:    b2_n  = spiRXD;
            3'd3:    b3_n  = spiRXD;
            default: ;
          endcase
          if (byte_cnt == 3'd3) begin
            state_n = sCHECK;
          end else begin
            byte_n = byte_cnt + 3'd1;
          end
        end
      end
      sCHECK: begin
        case (cmd)
          IDX_CMD0: begin
            if (r1 == R1_IDLE) begin
              advance = 1'b1;
              adv_cmd = IDX_CMD8;
            end else begin
              fail      = 1'b1;
              fail_code = ERR_CMD0;
            end
          end
          IDX_CMD8: begin
            if (r1 == R1_IDLE && ext_b2 == CMD8_VHS && ext_b3 == CMD8_CHECK) begin
              advance = 1'b1;
              adv_cmd = IDX_CMD55;
            end else begin
              fail      = 1'b1;
              fail_code = ERR_CMD8;
            end
          end
          IDX_CMD55: begin
            if (r1 == R1_READY || r1 == R1_IDLE) begin
              advance = 1'b1;
              adv_cmd = IDX_ACMD41;
            end else begin
              fail      = 1'b1;
              fail_code = ERR_ACMD41;
            end
          end
          IDX_ACMD41: begin
            if (r1 == R1_READY) begin
              advance = 1'b1;
              adv_cmd = IDX_CMD58;
            end else if (r1 == R1_IDLE && retry_cnt != RETRY_LAST) begin
              retry_n = retry_cnt + 1'b1;
              advance = 1'b1;
              adv_cmd = IDX_CMD55;
            end else begin
              if (r1 == R1_IDLE) begin
                retry_n = retry_cnt + 1'b1;
              end
              fail      = 1'b1;
              fail_code = ERR_ACMD41;
            end
          end
          IDX_CMD58: begin
            if (r1 == R1_READY) begin
              state_n = sDONE;
              cs_n    = 1'b1;
              fast_n  = 1'b1;
              busy_n  = 1'b0;
              done_n  = 1'b1;
              hc_n    = ccs;
            end else begin
              fail      = 1'b1;
              fail_code = ERR_CMD58;
            end
          end
          // Unused index values cannot occur; fail safe rather than hang.
          default: begin
            fail      = 1'b1;
            fail_code = ERR_CMD0;
          end
        endcase
      end
      default: state_n = sIDLE;
    endcase

    // Every command starts with a deselected gap byte.
    if (advance) begin
      state_n = sGAP;
      cmd_n   = adv_cmd;
      cs_n    = 1'b1;
    end

    if (fail) begin
      state_n = sERR;
      cs_n    = 1'b1;
      fast_n  = 1'b0;
      busy_n  = 1'b0;
      ierr_n  = 1'b1;
      code_n  = fail_code;
    end
  end

endmodule

// File: tb/tb_sd_init_seq.sv
// Bench for sd_init_seq: SPI byte engine plus SD card responder, with a
// reference model that predicts the transmitted byte stream and final status.
module tb_sd_init_seq;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [7:0] spiTXD;
  logic       spiGO;
  logic       spiDONE;
  logic [7:0] spiRXD;
  logic       sdCS;
  logic       spiFAST;
  logic       busy;
  logic       initDONE;
  logic       initERR;
  logic [3:0] errCODE;
  logic       sdHC;

  localparam int RETRIES = 4;

  always #5 clk = ~clk;

  sd_init_seq #(
    .DUMMY_BYTES    (10),
    .RSP_WAIT       (8),
    .ACMD41_RETRIES (RETRIES)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .spiTXD   (spiTXD),
    .spiGO    (spiGO),
    .spiDONE  (spiDONE),
    .spiRXD   (spiRXD),
    .sdCS     (sdCS),
    .spiFAST  (spiFAST),
    .busy     (busy),
    .initDONE (initDONE),
    .initERR  (initERR),
    .errCODE  (errCODE),
    .sdHC     (sdHC)
  );

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Card behaviour knobs.
  int         card_busy;   // number of ACMD41 "01" replies before "00"; <0 = forever
  bit         card_silent;
  logic [7:0] card_echo;
  logic [7:0] card_ocr0;
  int         card_lead;   // 0xFF bytes before R1

  // Card state.
  logic [7:0] resp_q[$];
  logic [7:0] frm[6];
  int         fcnt;
  int         acmd_seen;

  // Observed and predicted byte streams, {cs, byte}.
  logic [8:0] log_q[$];
  logic [8:0] exp_q[$];
  logic       exp_done, exp_err, exp_hc;
  logic [3:0] exp_code;

  task automatic card_respond(input logic [7:0] c);
    if (card_silent) return;
    repeat (card_lead) resp_q.push_back(8'hFF);
    case (c)
      8'h40: resp_q.push_back(8'h01);
      8'h48: begin
        resp_q.push_back(8'h01); resp_q.push_back(8'h00); resp_q.push_back(8'h00);
        resp_q.push_back(8'h01); resp_q.push_back(card_echo);
      end
      8'h77: resp_q.push_back(8'h01);
      8'h69: begin
        resp_q.push_back((card_busy < 0 || acmd_seen < card_busy) ? 8'h01 : 8'h00);
        acmd_seen++;
      end
      8'h7A: begin
        resp_q.push_back(8'h00); resp_q.push_back(card_ocr0); resp_q.push_back(8'hFF);
        resp_q.push_back(8'h80); resp_q.push_back(8'h00);
      end
      default: ;
    endcase
  endtask

  // Returns the MISO byte for this transfer, then lets the card see the MOSI byte.
  task automatic card_xfer(input logic [7:0] tx, input logic cs, output logic [7:0] rx);
    rx = (resp_q.size() > 0) ? resp_q.pop_front() : 8'hFF;
    if (cs) begin
      fcnt = 0;
    end else if (fcnt == 0) begin
      if (tx[7:6] == 2'b01) begin
        frm[0] = tx;
        fcnt   = 1;
      end
    end else begin
      frm[fcnt] = tx;
      fcnt++;
      if (fcnt == 6) begin
        card_respond(frm[0]);
        fcnt = 0;
      end
    end
  endtask

  // SPI byte engine with random latency and occasional stray DONE pulses.
  logic [7:0] cur_tx, cur_rx;
  logic       cur_cs, prev_cs;
  int         lat;
  bit         eng_busy;

  initial begin : engine
    spiDONE  = 1'b0;
    spiRXD   = 8'hFF;
    eng_busy = 1'b0;
    prev_cs  = 1'b1;
    forever begin
      @(negedge clk);
      spiDONE = 1'b0;
      if (reset) begin
        eng_busy = 1'b0;
      end else if (eng_busy) begin
        chk_eq("txd_hold", spiTXD, cur_tx);
        chk_eq("cs_hold", sdCS, cur_cs);
        chk_eq("go_while_busy", spiGO, 1'b0);
        lat--;
        if (lat == 0) begin
          spiDONE  = 1'b1;
          spiRXD   = cur_rx;
          eng_busy = 1'b0;
        end
      end else if (spiGO) begin
        chk_eq("cs_setup", sdCS, prev_cs);
        cur_tx = spiTXD;
        cur_cs = sdCS;
        log_q.push_back({sdCS, spiTXD});
        card_xfer(spiTXD, sdCS, cur_rx);
        lat      = $urandom_range(1, 4);
        eng_busy = 1'b1;
      end else if ($urandom_range(0, 15) == 0) begin
        spiDONE = 1'b1;
        spiRXD  = 8'h00;
      end
      prev_cs = sdCS;
    end
  end

  // Reference model: expected stream from the protocol rules.
  task automatic push_cmd(input logic [7:0] c, input logic [31:0] arg, input logic [7:0] crc,
                          input int nrsp);
    exp_q.push_back({1'b1, 8'hFF});
    exp_q.push_back({1'b0, c});
    for (int k = 3; k >= 0; k--) exp_q.push_back({1'b0, arg[8*k +: 8]});
    exp_q.push_back({1'b0, crc});
    repeat (nrsp) exp_q.push_back({1'b0, 8'hFF});
  endtask

  task automatic build_expected();
    int attempts;
    bit acmd_fail;
    exp_q.delete();
    exp_done = 1'b0; exp_err = 1'b0; exp_hc = 1'b0; exp_code = 4'd0;
    repeat (10) exp_q.push_back({1'b1, 8'hFF});
    if (card_silent) begin
      push_cmd(8'h40, 32'h0, 8'h95, 8);
      exp_err = 1'b1; exp_code = 4'd5;
      return;
    end
    push_cmd(8'h40, 32'h0, 8'h95, card_lead + 1);
    push_cmd(8'h48, 32'h1AA, 8'h87, card_lead + 5);
    if (card_echo != 8'hAA) begin
      exp_err = 1'b1; exp_code = 4'd2;
      return;
    end
    acmd_fail = (card_busy < 0 || card_busy >= RETRIES);
    attempts  = acmd_fail ? RETRIES : card_busy + 1;
    for (int a = 0; a < attempts; a++) begin
      push_cmd(8'h77, 32'h0, 8'h65, card_lead + 1);
      push_cmd(8'h69, 32'h4000_0000, 8'h77, card_lead + 1);
    end
    if (acmd_fail) begin
      exp_err = 1'b1; exp_code = 4'd3;
      return;
    end
    push_cmd(8'h7A, 32'h0, 8'hFD, card_lead + 5);
    exp_done = 1'b1;
    exp_hc   = card_ocr0[6];
  endtask

  task automatic check_reset_vals(input string tag);
    chk_eq({tag, "/spiTXD"}, spiTXD, 8'hFF);
    chk_eq({tag, "/spiGO"}, spiGO, 1'b0);
    chk_eq({tag, "/sdCS"}, sdCS, 1'b1);
    chk_eq({tag, "/spiFAST"}, spiFAST, 1'b0);
    chk_eq({tag, "/busy"}, busy, 1'b0);
    chk_eq({tag, "/initDONE"}, initDONE, 1'b0);
    chk_eq({tag, "/initERR"}, initERR, 1'b0);
    chk_eq({tag, "/errCODE"}, errCODE, 4'd0);
    chk_eq({tag, "/sdHC"}, sdHC, 1'b0);
  endtask

  task automatic begin_case(input string name, input int b, input bit sil,
                            input logic [7:0] echo, input logic [7:0] ocr0, input int lead);
    card_busy = b; card_silent = sil; card_echo = echo; card_ocr0 = ocr0; card_lead = lead;
    resp_q.delete(); fcnt = 0; acmd_seen = 0;
    log_q.delete();
    build_expected();
    @(negedge clk);
    chk_eq({name, "/idle_before"}, busy, 1'b0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk_eq({name, "/busy_rise"}, busy, 1'b1);
    chk_eq({name, "/flags_clear"}, {initDONE, initERR, errCODE, sdHC, spiFAST}, 8'h00);
    chk_eq({name, "/go_not_yet"}, spiGO, 1'b0);
    @(negedge clk);
    chk_eq({name, "/first_go"}, spiGO, 1'b1);
  endtask

  task automatic finish_case(input string name);
    int cyc = 0;
    // A start while busy must not disturb the sequence.
    repeat ($urandom_range(5, 60)) @(negedge clk);
    if (busy) begin
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    while (busy && cyc < 20000) begin
      @(negedge clk);
      cyc++;
    end
    chk_eq({name, "/terminated"}, busy, 1'b0);
    chk_eq({name, "/nbytes"}, log_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < log_q.size(); i++)
      chk_eq($sformatf("%s/byte%0d", name, i), log_q[i], exp_q[i]);
    chk_eq({name, "/initDONE"}, initDONE, exp_done);
    chk_eq({name, "/initERR"}, initERR, exp_err);
    chk_eq({name, "/errCODE"}, errCODE, exp_code);
    chk_eq({name, "/sdHC"}, sdHC, exp_hc);
    chk_eq({name, "/spiFAST"}, spiFAST, exp_done);
    chk_eq({name, "/sdCS"}, sdCS, 1'b1);
  endtask

  task automatic run_case(input string name, input int b, input bit sil,
                          input logic [7:0] echo, input logic [7:0] ocr0, input int lead);
    begin_case(name, b, sil, echo, ocr0, lead);
    finish_case(name);
  endtask

  initial begin : watchdog
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin : main
    int cyc;
    reset = 1'b1;
    start = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_vals("reset");
    reset = 1'b0;

    run_case("nominal", 0, 1'b0, 8'hAA, 8'hE0, 1);
    run_case("busy3", 3, 1'b0, 8'hAA, 8'hE0, 1);
    run_case("acmd_forever", -1, 1'b0, 8'hAA, 8'hE0, 1);
    run_case("silent", 0, 1'b0 | 1'b1, 8'hAA, 8'hE0, 1);
    run_case("bad_echo", 0, 1'b0, 8'h55, 8'hE0, 1);
    run_case("sdsc_lead7", 0, 1'b0, 8'hAA, 8'h80, 7);

    // Reset asserted while the CMD8 response is being read.
    begin_case("rst_mid", 0, 1'b0, 8'hAA, 8'hE0, 1);
    cyc = 0;
    while (log_q.size() < 27 && cyc < 2000) begin
      @(negedge clk);
      cyc++;
    end
    chk_eq("rst_mid/reached_cmd8_rsp", (log_q.size() >= 27), 1'b1);
    #2 reset = 1'b1;
    #1 check_reset_vals("rst_mid");
    @(negedge clk);
    reset = 1'b0;
    run_case("after_reset", 1, 1'b0, 8'hAA, 8'hC0, 1);

    for (int r = 0; r < 12; r++) begin
      int         b;
      bit         sil;
      logic [7:0] echo;
      b    = int'($urandom_range(0, 5));
      sil  = ($urandom_range(0, 7) == 0);
      echo = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255)) : 8'hAA;
      run_case($sformatf("rand%0d", r), b, sil, echo, 8'($urandom), int'($urandom_range(0, 7)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
